// File: rtl/lift_row_seq.sv
// Sequences one lift_step over a RAM row; LIFT_SAT_EN selects saturating write-back, else 8-bit truncation.
// Latency: ROW_LEN*(7+L)+2 cycles from start_i to done_o, where L is the ISSUE-to-lift_update_i delay.
// Backpressure: WAIT holds without timeout until lift_update_i; start_i is ignored while busy.
`timescale 1ns/1ps
module lift_row_seq #(
  parameter int ROW_LEN = 8,
  parameter int AW      = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              inverse_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  output logic [2:0]        lift_flags_o,
  output logic              lift_update_o,
  output logic [7:0]        lift_left_o,
  output logic [7:0]        lift_sam_o,
  output logic [7:0]        lift_right_o,
  input  logic signed [8:0] lift_res_i,
  input  logic              lift_update_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_L, S_RD_S, S_RD_R, S_CAP, S_ISSUE, S_WAIT, S_WRITE, S_NEXT, S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_ODD  = AW'(ROW_LEN - 1);
  localparam logic [AW-1:0] LAST_EVEN = AW'(ROW_LEN - 2);

  state_t                state_q, state_d;
  logic [AW-1:0]         idx_q;
  logic                  pass_q;
  logic                  inv_q;
  logic [7:0]            left_q, sam_q, right_q;
  logic signed [8:0]     res_q;

  logic                  predict;
  logic                  last_in_pass;
  logic [AW-1:0]         left_idx, right_idx;
  logic [7:0]            wb_data;

  // Forward runs predict first; inverse runs update first.
  assign predict      = inv_q ? pass_q : ~pass_q;
  assign last_in_pass = predict ? (idx_q == LAST_ODD) : (idx_q == LAST_EVEN);
  assign left_idx     = (idx_q == '0) ? AW'(1) : idx_q - AW'(1);
  assign right_idx    = (idx_q == LAST_ODD) ? LAST_EVEN : idx_q + AW'(1);

`ifdef LIFT_SAT_EN
  // A predict result is sam minus a non-negative term, so bit 8 set means negative.
  // An update result is sam plus a non-negative term, so bit 8 set means above 255.
  assign wb_data = res_q[8] ? (predict ? 8'd0 : 8'd255) : res_q[7:0];
`else
  logic unused_res_msb;
  assign unused_res_msb = res_q[8];
  assign wb_data        = res_q[7:0];
`endif

  assign lift_left_o  = left_q;
  assign lift_sam_o   = sam_q;
  assign lift_right_o = right_q;
  assign lift_flags_o = (state_q == S_IDLE || state_q == S_DONE) ? 3'b000
                                                                 : {1'b1, ~inv_q, predict};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      pass_q  <= 1'b0;
      inv_q   <= 1'b0;
      left_q  <= 8'd0;
      sam_q   <= 8'd0;
      right_q <= 8'd0;
      res_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            inv_q  <= inverse_i;
            pass_q <= 1'b0;
            idx_q  <= inverse_i ? '0 : AW'(1);
          end
        end
        S_RD_S:  left_q  <= mem_rdata_i;
        S_RD_R:  sam_q   <= mem_rdata_i;
        S_CAP:   right_q <= mem_rdata_i;
        S_WAIT: begin
          if (lift_update_i) res_q <= lift_res_i;
        end
        S_NEXT: begin
          if (!last_in_pass) begin
            idx_q <= idx_q + AW'(2);
          end else if (!pass_q) begin
            pass_q <= 1'b1;
            idx_q  <= predict ? '0 : AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    mem_addr_o    = '0;
    mem_rd_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_wdata_o   = 8'd0;
    lift_update_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = S_RD_L;
      end
      S_RD_L: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = left_idx;
        state_d    = S_RD_S;
      end
      S_RD_S: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = idx_q;
        state_d    = S_RD_R;
      end
      S_RD_R: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = right_idx;
        state_d    = S_CAP;
      end
      S_CAP:   state_d = S_ISSUE;
      S_ISSUE: begin
        lift_update_o = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (lift_update_i) state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = idx_q;
        mem_wdata_o = wb_data;
        state_d     = S_NEXT;
      end
      S_NEXT: begin
        if (!last_in_pass || !pass_q) state_d = S_RD_L;
        else                          state_d = S_DONE;
      end
      S_DONE: begin
        busy_o  = 1'b0;
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_o  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lift_row_seq.sv
// Directed bench for lift_row_seq: RAM and a fixed-latency lift model, checks write-back order/data and timing.
`timescale 1ns/1ps
module tb_lift_row_seq;
  localparam int ROW_LEN = 8;
  localparam int AW      = 3;
  localparam int LAT     = 2;

  logic              clk = 1'b0;
  logic              rst_i, start_i, inverse_i;
  logic              busy_o, done_o, mem_rd_o, mem_we_o, lift_update_o, lift_update_i;
  logic [AW-1:0]     mem_addr_o;
  logic [7:0]        mem_rdata_i, mem_wdata_o, lift_left_o, lift_sam_o, lift_right_o;
  logic [2:0]        lift_flags_o;
  logic signed [8:0] lift_res_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Initial rows and hand-computed write-back sequences (addr, data).
  logic [7:0]    row_a [8]   = '{8'd68, 8'd218, 8'd163, 8'd231, 8'd164, 8'd250, 8'd160, 8'd203};
  logic [AW-1:0] exp_a_ad[8] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd2, 3'd4, 3'd6};
  logic [7:0]    exp_a_d [8] = '{8'd103, 8'd68, 8'd88, 8'd43, 8'd120, 8'd206, 8'd203, 8'd193};
  logic [7:0]    row_b [8]   = '{8'd10, 8'd100, 8'd30, 8'd120, 8'd50, 8'd140, 8'd70, 8'd160};
  logic [AW-1:0] exp_b_ad[8] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd1, 3'd3, 3'd5, 3'd7};
  logic [7:0]    exp_b_d [8] = '{8'd60, 8'd85, 8'd115, 8'd145, 8'd28, 8'd20, 8'd10, 8'd15};

  logic [7:0]    ram [ROW_LEN];
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr_p;
  int            lat_cnt = 0;
  logic [8:0]    res_hold;
  int            n_issue = 0, n_wr = 0, n_done = 0, done_cyc = 0, start_cyc = 0;
  int            ovr_a_n = -1, ovr_b_n = -1, ovr_a_v = 0, ovr_b_v = 0;
  int            ml, mr, ms, mv;
  logic [7:0]    iss_left [16], iss_right [16];
  logic [2:0]    iss_flags [16];
  logic [AW-1:0] wr_addr [16];
  logic [7:0]    wr_data [16];

  lift_row_seq #(.ROW_LEN(ROW_LEN), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .inverse_i(inverse_i),
    .busy_o(busy_o), .done_o(done_o),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_rdata_i(mem_rdata_i),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .lift_flags_o(lift_flags_o), .lift_update_o(lift_update_o),
    .lift_left_o(lift_left_o), .lift_sam_o(lift_sam_o), .lift_right_o(lift_right_o),
    .lift_res_i(lift_res_i), .lift_update_i(lift_update_i)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // RAM with one-cycle read latency plus lift model (predict/update, latency LAT).
  initial begin
    mem_rdata_i   = 8'd0;
    lift_update_i = 1'b0;
    lift_res_i    = '0;
    forever begin
      @(negedge clk);
      mem_rdata_i = rd_pend ? ram[rd_addr_p] : 8'd0;
      rd_pend     = mem_rd_o;
      rd_addr_p   = mem_addr_o;
      if (mem_we_o) begin
        if (n_wr < 16) begin
          wr_addr[n_wr] = mem_addr_o;
          wr_data[n_wr] = mem_wdata_o;
        end
        n_wr++;
        ram[mem_addr_o] = mem_wdata_o;
      end
      if (done_o) begin
        n_done++;
        done_cyc = cyc;
      end
      lift_update_i = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          lift_update_i = 1'b1;
          lift_res_i    = res_hold;
        end
      end
      if (lift_update_o) begin
        ml = int'(lift_left_o);
        mr = int'(lift_right_o);
        ms = int'(lift_sam_o);
        mv = lift_flags_o[0] ? ms - ((ml + mr) >>> 1) : ms + ((ml + mr + 2) >>> 2);
        if (n_issue == ovr_a_n) mv = ovr_a_v;
        if (n_issue == ovr_b_n) mv = ovr_b_v;
        res_hold = mv[8:0];
        if (n_issue < 16) begin
          iss_left[n_issue]  = lift_left_o;
          iss_right[n_issue] = lift_right_o;
          iss_flags[n_issue] = lift_flags_o;
        end
        n_issue++;
        lat_cnt = LAT;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_ram(input logic [7:0] row [8]);
    for (int i = 0; i < ROW_LEN; i++) ram[i] = row[i];
  endtask

  task automatic start_row(input logic inv);
    @(negedge clk);
    n_wr = 0; n_issue = 0; n_done = 0;
    inverse_i = inv;
    start_i   = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start_i   = 1'b0;
    inverse_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, (n_done > 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_writes(input string tag, input logic [AW-1:0] ad [8], input logic [7:0] d [8]);
    check({tag, "_n_writes"}, n_wr, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_wr_addr%0d", tag, i), wr_addr[i], ad[i]);
      check($sformatf("%s_wr_data%0d", tag, i), wr_data[i], d[i]);
    end
  endtask

  initial begin
    int k;
    rst_i = 1'b1; start_i = 1'b0; inverse_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  busy_o, 0);
    check("rst_done",  done_o, 0);
    check("rst_rd",    mem_rd_o, 0);
    check("rst_we",    mem_we_o, 0);
    check("rst_upd",   lift_update_o, 0);
    check("rst_flags", lift_flags_o, 3'b000);
    check("rst_addr",  mem_addr_o, 0);
    check("rst_ops",   {lift_left_o, lift_sam_o, lift_right_o}, 0);
    rst_i = 1'b0;

    // Forward row with boundary and latency checks.
    load_ram(row_a);
    start_row(1'b0);
    check("fwd_busy_after_start", busy_o, 1);
    wait_done("fwd", 300);
    check("fwd_latency_cycles", done_cyc - start_cyc + 1, 74);
    check_writes("fwd", exp_a_ad, exp_a_d);
    check("fwd_i7_left",  iss_left[3], 160);
    check("fwd_i7_right", iss_right[3], 160);
    check("fwd_i0_left",  iss_left[4], 103);
    check("fwd_i0_right", iss_right[4], 103);
    check("fwd_flags_pred", iss_flags[0], 3'b111);
    check("fwd_flags_upd",  iss_flags[4], 3'b110);
    @(negedge clk);
    check("fwd_idle_busy", busy_o, 0);

    // Inverse row: update pass on evens first.
    load_ram(row_b);
    start_row(1'b1);
    wait_done("inv", 300);
    check_writes("inv", exp_b_ad, exp_b_d);
    check("inv_flags_first",  iss_flags[0], 3'b100);
    check("inv_flags_second", iss_flags[4], 3'b101);

    // Out-of-range lift results: -5 on a predict sample, 300 on an update sample.
    load_ram(row_a);
    ovr_a_n = 0; ovr_a_v = -5;
    ovr_b_n = 4; ovr_b_v = 300;
    start_row(1'b0);
    wait_done("sat", 300);
    check("neg_addr", wr_addr[0], 1);
    check("big_addr", wr_addr[4], 0);
`ifdef LIFT_SAT_EN
    check("neg_wdata", wr_data[0], 8'd0);
    check("big_wdata", wr_data[4], 8'd255);
`else
    check("neg_wdata", wr_data[0], 8'hFB);
    check("big_wdata", wr_data[4], 8'h2C);
`endif
    ovr_a_n = -1; ovr_b_n = -1;

    // Reset during WAIT of the third sample.
    load_ram(row_a);
    start_row(1'b0);
    k = 0;
    while (k < 3 && n_checks < 100000) begin
      @(negedge clk);
      if (lift_update_o) k++;
      if (busy_o == 1'b0) break;
    end
    check("rst_mid_third_issue", k, 3);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("rst_mid_busy",  busy_o, 0);
    check("rst_mid_rd",    mem_rd_o, 0);
    check("rst_mid_we",    mem_we_o, 0);
    check("rst_mid_upd",   lift_update_o, 0);
    check("rst_mid_done",  done_o, 0);
    check("rst_mid_flags", lift_flags_o, 3'b000);
    repeat (10) @(negedge clk);
    check("rst_mid_n_writes", n_wr, 2);
    check("rst_mid_no_done",  n_done, 0);
    check("rst_mid_still_idle", busy_o, 0);

    // Restart, with a stray start pulse mid-row that must be ignored.
    load_ram(row_a);
    start_row(1'b0);
    repeat (20) @(negedge clk);
    inverse_i = 1'b1;
    start_i   = 1'b1;
    @(negedge clk);
    start_i   = 1'b0;
    inverse_i = 1'b0;
    wait_done("restart", 300);
    check("restart_latency_cycles", done_cyc - start_cyc + 1, 74);
    check_writes("restart", exp_a_ad, exp_a_d);
    repeat (100) @(negedge clk);
    check("restart_single_done", n_done, 1);
    check("restart_no_extra_writes", n_wr, 8);
    check("restart_idle", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
